pipe_ctrl: RTL and testbench

- Central sequencer for the 3-stage (IF / EX / WB) RV32I pipeline.
- Each cycle it selects the next-PC source, stalls and squashes stages for taken branches, jumps and slow data-memory accesses, and drives WB→EX forwarding selects.
- Sits beside the IF immediate path: JAL redirects in IF using the IF-generated immediate; branches and JALR resolve in EX.
- Keeps saturating bubble and redirect performance counters.

---
 rtl/pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: next-PC select, stall/squash sequencing, WB->EX forwarding
// and saturating performance counters for the 3-stage RV32I pipeline.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_if_inst,
    input  logic [31:0]      i_ex_inst,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_wb_inst,
    input  logic             i_wb_valid,
    input  logic             i_ex_br_taken,
    input  logic             i_dmem_ready,
    output logic [1:0]       o_pc_sel,
    output logic             o_if_stall,
    output logic             o_ex_stall,
    output logic             o_ex_kill,
    output logic             o_dmem_req,
    output logic             o_fwd_a,
    output logic             o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_bubble_cnt,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_ARI_I  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ARI_R  = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_nxt;
    logic            w_err_set;
    logic            w_bub_inc;
    logic            w_redir_inc;

    logic [4:0] w_if_op;
    logic [4:0] w_ex_op;
    logic [4:0] w_wb_op;
    logic       w_ex_mem;
    logic       w_ex_redir;
    logic       w_if_jal;
    logic       w_wb_wr;
    logic [4:0] w_wb_rd;
    logic [4:0] w_ex_rs1;
    logic [4:0] w_ex_rs2;
    logic       w_ex_use_a;
    logic       w_ex_use_b;

    assign w_if_op  = i_if_inst[6:2];
    assign w_ex_op  = i_ex_inst[6:2];
    assign w_wb_op  = i_wb_inst[6:2];
    assign w_wb_rd  = i_wb_inst[11:7];
    assign w_ex_rs1 = i_ex_inst[19:15];
    assign w_ex_rs2 = i_ex_inst[24:20];

    assign w_ex_mem = i_ex_valid &&
                      (w_ex_op == OP_LOAD || w_ex_op == OP_STORE);
    assign w_ex_redir = i_ex_valid &&
                        (w_ex_op == OP_JALR ||
                         (w_ex_op == OP_BRANCH && i_ex_br_taken));
    assign w_if_jal = (w_if_op == OP_JAL);

    assign w_wb_wr = i_wb_valid && (w_wb_rd != 5'd0) &&
                     (w_wb_op == OP_ARI_R || w_wb_op == OP_ARI_I ||
                      w_wb_op == OP_LOAD  || w_wb_op == OP_LUI   ||
                      w_wb_op == OP_AUIPC || w_wb_op == OP_JAL   ||
                      w_wb_op == OP_JALR);
    assign w_ex_use_a = !(w_ex_op == OP_LUI || w_ex_op == OP_AUIPC ||
                          w_ex_op == OP_JAL);
    assign w_ex_use_b = (w_ex_op == OP_ARI_R || w_ex_op == OP_STORE ||
                         w_ex_op == OP_BRANCH);

    // Forwarding is muted while in reset so every output has a known value.
    assign o_fwd_a = i_rst_n && w_wb_wr && i_ex_valid &&
                     (w_wb_rd == w_ex_rs1) && w_ex_use_a;
    assign o_fwd_b = i_rst_n && w_wb_wr && i_ex_valid &&
                     (w_wb_rd == w_ex_rs2) && w_ex_use_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= BOOT;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wait_nxt  = r_wait;
        o_pc_sel    = 2'd0;
        o_if_stall  = 1'b0;
        o_ex_stall  = 1'b0;
        o_ex_kill   = 1'b0;
        o_dmem_req  = 1'b0;
        w_err_set   = 1'b0;
        w_bub_inc   = 1'b0;
        w_redir_inc = 1'b0;
        if (!i_rst_n) begin
            o_pc_sel  = 2'd3;
            o_ex_kill = 1'b1;
        end else begin
            unique case (r_state)
                BOOT: begin
                    o_pc_sel  = 2'd3;
                    o_ex_kill = 1'b1;
                    w_next    = RUN;
                end
                RUN: begin
                    if (w_ex_mem) begin
                        o_dmem_req = 1'b1;
                        if (i_dmem_ready) begin
                            o_pc_sel = w_if_jal ? 2'd1 : 2'd0;
                        end else begin
                            o_if_stall = 1'b1;
                            o_ex_stall = 1'b1;
                            w_bub_inc  = 1'b1;
                            w_wait_nxt = WW'(1);
                            w_next     = MEM_WAIT;
                        end
                    end else if (w_ex_redir) begin
                        o_pc_sel    = 2'd2;
                        o_ex_kill   = 1'b1;
                        w_redir_inc = 1'b1;
                        w_bub_inc   = 1'b1;
                    end else if (w_if_jal) begin
                        o_pc_sel = 2'd1;
                    end
                end
                MEM_WAIT: begin
                    o_dmem_req = 1'b1;
                    if (i_dmem_ready) begin
                        o_pc_sel = w_if_jal ? 2'd1 : 2'd0;
                        w_next   = RUN;
                    end else if (r_wait == WW'(MEM_TIMEOUT)) begin
                        // Abandon the access; EX advances as if it completed.
                        w_err_set = 1'b1;
                        o_pc_sel  = w_if_jal ? 2'd1 : 2'd0;
                        w_next    = RUN;
                    end else begin
                        o_if_stall = 1'b1;
                        o_ex_stall = 1'b1;
                        w_bub_inc  = 1'b1;
                        w_wait_nxt = r_wait + WW'(1);
                    end
                end
                default: w_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_mem_err      <= 1'b0;
            o_bubble_cnt   <= '0;
            o_redirect_cnt <= '0;
        end else begin
            if (w_err_set)
                o_mem_err <= 1'b1;
            if (w_bub_inc && o_bubble_cnt != '1)
                o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
            if (w_redir_inc && o_redirect_cnt != '1)
                o_redirect_cnt <= o_redirect_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus hand-written
// multi-cycle sequences (stalls, timeout, saturation, reset abort).
module tb_pipe_ctrl;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI5 = 32'h00100293;
    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI0 = 32'h00100013;
    localparam logic [31:0] ADD6  = 32'h00528333;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] JAL   = 32'h000000EF;
    localparam logic [31:0] JALR  = 32'h00008067;
    localparam logic [31:0] LW    = 32'h0000A383;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] SW_R5 = 32'h0020A2A3;
    localparam logic [31:0] LUI5  = 32'h000282B7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_inst, ex_inst, wb_inst;
    logic        ex_valid, wb_valid, br_taken, ready;
    logic [1:0]  pc_sel;
    logic        if_stall, ex_stall, ex_kill, dmem_req;
    logic        fwd_a, fwd_b, mem_err;
    logic [3:0]  bubble_cnt, redirect_cnt;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_inst(if_inst), .i_ex_inst(ex_inst),
        .i_ex_valid(ex_valid), .i_wb_inst(wb_inst),
        .i_wb_valid(wb_valid), .i_ex_br_taken(br_taken),
        .i_dmem_ready(ready), .o_pc_sel(pc_sel),
        .o_if_stall(if_stall), .o_ex_stall(ex_stall),
        .o_ex_kill(ex_kill), .o_dmem_req(dmem_req),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_mem_err(mem_err),
        .o_bubble_cnt(bubble_cnt), .o_redirect_cnt(redirect_cnt)
    );

    typedef struct {
        logic [31:0] ifi;
        logic [31:0] exi;
        logic        exv;
        logic [31:0] wbi;
        logic        wbv;
        logic        tk;
        logic        rdy;
        logic [1:0]  pc;
        logic        kill;
        logic        req;
        logic        fa;
        logic        fb;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, settle 2ns, well away from the rising edge.
    task automatic drive(input logic [31:0] ifi, input logic [31:0] exi,
                         input logic exv, input logic [31:0] wbi,
                         input logic wbv, input logic tk,
                         input logic rdy);
        @(negedge clk);
        if_inst = ifi; ex_inst = exi; ex_valid = exv;
        wb_inst = wbi; wb_valid = wbv; br_taken = tk; ready = rdy;
        #2;
    endtask

    task automatic idle();
        drive(NOP, NOP, 1'b1, NOP, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{ADDI5, BEQ,  1, NOP,   1, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[1]  = '{ADDI5, BEQ,  0, NOP,   1, 1, 0, 2'd0, 0, 0, 0, 0};
        tbl[2]  = '{JAL,   ADD6, 1, NOP,   1, 0, 0, 2'd1, 0, 0, 0, 0};
        tbl[3]  = '{JAL,   JALR, 1, NOP,   1, 0, 0, 2'd2, 1, 0, 0, 0};
        tbl[4]  = '{JAL,   BEQ,  1, NOP,   1, 1, 0, 2'd2, 1, 0, 0, 0};
        tbl[5]  = '{NOP,   ADD6, 1, ADDI5, 1, 0, 0, 2'd0, 0, 0, 1, 1};
        tbl[6]  = '{NOP,   ADD6, 1, ADDI0, 1, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[7]  = '{NOP,   ADD6, 1, ADDI5, 0, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[8]  = '{NOP,   LUI5, 1, ADDI5, 1, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[9]  = '{NOP,   SW,   1, ADDI1, 1, 0, 1, 2'd0, 0, 1, 1, 0};
        tbl[10] = '{NOP,   LW,   1, ADDI1, 1, 0, 1, 2'd0, 0, 1, 1, 0};
        tbl[11] = '{NOP,   ADD6, 0, ADDI5, 1, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[12] = '{NOP,   ADD6, 1, SW_R5, 1, 0, 0, 2'd0, 0, 0, 0, 0};

        rst_n = 1'b0;
        if_inst = NOP; ex_inst = LW; ex_valid = 1'b1;
        wb_inst = NOP; wb_valid = 1'b1; br_taken = 1'b0; ready = 1'b0;

        // Reset held 3 cycles, then one BOOT cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("rst_pc_sel", 32'(pc_sel), 32'd3);
            chk("rst_kill", 32'(ex_kill), 32'd1);
            chk("rst_req", 32'(dmem_req), 32'd0);
            chk("rst_stall", 32'(if_stall | ex_stall), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ex_inst = NOP;
        #2;
        chk("boot_pc_sel", 32'(pc_sel), 32'd3);
        chk("boot_kill", 32'(ex_kill), 32'd1);
        idle();
        chk("run_pc_sel", 32'(pc_sel), 32'd0);
        chk("run_kill", 32'(ex_kill), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        chk("rst_redir", 32'(redirect_cnt), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);

        // Taken branch
        drive(ADDI5, BEQ, 1'b1, NOP, 1'b1, 1'b1, 1'b0);
        chk("br_pc_sel", 32'(pc_sel), 32'd2);
        chk("br_kill", 32'(ex_kill), 32'd1);
        idle();
        chk("br_redir_cnt", 32'(redirect_cnt), 32'd1);
        chk("br_bubble_cnt", 32'(bubble_cnt), 32'd1);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ifi, tbl[i].exi, tbl[i].exv, tbl[i].wbi,
                  tbl[i].wbv, tbl[i].tk, tbl[i].rdy);
            chk($sformatf("v%0d_pc_sel", i), 32'(pc_sel),
                32'(tbl[i].pc));
            chk($sformatf("v%0d_kill", i), 32'(ex_kill),
                32'(tbl[i].kill));
            chk($sformatf("v%0d_req", i), 32'(dmem_req),
                32'(tbl[i].req));
            chk($sformatf("v%0d_stall", i),
                32'(if_stall | ex_stall), 32'd0);
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
        end
        idle();
        chk("tbl_redir_cnt", 32'(redirect_cnt), 32'd3);
        chk("tbl_bubble_cnt", 32'(bubble_cnt), 32'd3);

        // Slow load: ready on the 4th cycle
        for (int k = 1; k <= 4; k++) begin
            drive(NOP, LW, 1'b1, NOP, 1'b1, 1'b0, k == 4);
            chk($sformatf("ld%0d_req", k), 32'(dmem_req), 32'd1);
            chk($sformatf("ld%0d_if_stall", k), 32'(if_stall),
                32'(k < 4));
            chk($sformatf("ld%0d_ex_stall", k), 32'(ex_stall),
                32'(k < 4));
        end
        idle();
        chk("ld_bubble_cnt", 32'(bubble_cnt), 32'd6);
        chk("ld_run_stall", 32'(if_stall), 32'd0);
        chk("ld_run_req", 32'(dmem_req), 32'd0);

        // Timeout: 4 stalled cycles, released on the 5th
        for (int k = 1; k <= 5; k++) begin
            drive(NOP, SW, 1'b1, NOP, 1'b1, 1'b0, 1'b0);
            chk($sformatf("to%0d_req", k), 32'(dmem_req), 32'd1);
            chk($sformatf("to%0d_stall", k), 32'(if_stall),
                32'(k < 5));
            chk($sformatf("to%0d_mem_err", k), 32'(mem_err), 32'd0);
        end
        idle();
        chk("to_mem_err", 32'(mem_err), 32'd1);
        chk("to_stall", 32'(if_stall | ex_stall), 32'd0);
        chk("to_bubble_cnt", 32'(bubble_cnt), 32'd10);
        drive(NOP, LW, 1'b1, NOP, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        chk("to_err_sticky", 32'(mem_err), 32'd1);

        // Saturation of both counters
        for (int k = 0; k < 14; k++)
            drive(NOP, BEQ, 1'b1, NOP, 1'b1, 1'b1, 1'b0);
        idle();
        chk("sat_redir_cnt", 32'(redirect_cnt), 32'd15);
        chk("sat_bubble_cnt", 32'(bubble_cnt), 32'd15);

        // Reset clears sticky error and counters
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rr_mem_err", 32'(mem_err), 32'd0);
        chk("rr_redir_cnt", 32'(redirect_cnt), 32'd0);
        chk("rr_bubble_cnt", 32'(bubble_cnt), 32'd0);
        idle();

        // Reset in MEM_WAIT drops the request at once
        drive(NOP, LW, 1'b1, NOP, 1'b1, 1'b0, 1'b0);
        drive(NOP, LW, 1'b1, NOP, 1'b1, 1'b0, 1'b0);
        chk("mw_req", 32'(dmem_req), 32'd1);
        chk("mw_stall", 32'(if_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mw_rst_req", 32'(dmem_req), 32'd0);
        chk("mw_rst_stall", 32'(if_stall | ex_stall), 32'd0);
        chk("mw_rst_pc_sel", 32'(pc_sel), 32'd3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
